wt_dcache_flush_ctrl: RTL and testbench
=======================================

// Module: wt_dcache_flush_ctrl
// PURPOSE
//   Sequences a full invalidation of the write-through data cache on fence/flush.
//   - Drains outstanding traffic, then walks every set and clears all ways through the tag-array port.
//   - Acks the controller when done.
//   - Sits between the CSR/controller flush request and the WT dcache tag arbiter.
//   - Is a low-priority requester of that arbiter.
// PARAMETERS
//   CVA6Cfg  config_pkg::cva6_cfg_t  (default: build config)  source of DcacheByteSize/SetAssoc/LineWidth
//   NumWays  CVA6Cfg.DcacheSetAssoc (8)                        ways cleared per tag write
//   NumSets  DcacheByteSize/(NumWays*DcacheLineWidth/8) (256)  sets walked; power of two, >=2
//   IdxW     $clog2(NumSets) (8)                               set index width
// PORTS
//   clk_i         in   1        core clock
//   rst_ni        in   1        asynchronous reset, active low
//   flush_i       in   1        one-cycle flush request from controller
//   busy_o        out  1        flush in progress (state != IDLE)
//   flush_ack_o   out  1        one-cycle pulse: cache fully invalidated
//   wbuf_empty_i  in   1        write buffer holds no entries
//   miss_busy_i   in   1        miss unit has outstanding refill
//   tag_req_o     out  1        tag-array write request
//   tag_gnt_i     in   1        tag-array arbiter grant
//   tag_idx_o     out  IdxW     set index of current request
//   tag_way_o     out  NumWays  way mask (all ones while requesting)
//   tag_valid_o   out  1        valid bit written (always 0 = invalidate)
//   flush_cycles_o out 32       cycles taken by last flush (DCACHE_FLUSH_STATS_EN only)
// BEHAVIOUR
//   Reset: state=IDLE, idx=0. All outputs 0, including flush_cycles_o.
//   FSM states IDLE -> DRAIN -> INVAL -> DONE -> IDLE. All state and idx are registered.
//   - IDLE: flush_i=1 -> DRAIN next cycle. flush_i in any other state is ignored (no queueing).
//   - DRAIN: wbuf_empty_i && !miss_busy_i sampled high -> INVAL next cycle, idx<=0.
//     Otherwise stay; no timeout.
//   - INVAL: tag_req_o=1, tag_way_o='1, tag_valid_o=0, tag_idx_o=idx.
//     Request and idx stay stable until tag_gnt_i (valid/ready rule).
//     On gnt: idx<=idx+1. Gnt with idx==NumSets-1 -> DONE, idx wraps to 0.
//     gnt while tag_req_o=0 is ignored.
//   - DONE: flush_ack_o=1 for exactly this cycle, then IDLE.
//   Latency: with conditions met and gnt tied high, flush_i at cycle 0 gives ack at cycle NumSets+2.
//   - This is cycle 258 for the default config.
//   - Each gnt-low cycle in INVAL adds one cycle.
//   - busy_o is high from cycle 1 through the ack cycle inclusive.
//   flush_i in the DONE cycle is ignored. A new flush needs flush_i while in IDLE.
//   Async reset mid-flush returns to IDLE immediately.
//   - No ack is issued; the partial walk is abandoned.
//   - The controller must re-request after reset.
//   tag_req_o, tag_way_o, tag_idx_o and tag_valid_o are 0 outside INVAL.
// CONFIGURATION
//   DCACHE_FLUSH_STATS_EN defined:
//   - 32-bit counter clears on IDLE->DRAIN and increments every busy cycle, saturating at 2^32-1.
//   - flush_cycles_o takes the final count in the DONE cycle and holds it until the next DONE.
//   DCACHE_FLUSH_STATS_EN undefined: counter absent; flush_cycles_o tied to 0.
// STRUCTURE
//   Shared package wt_cache_pkg holds:
//   - typedef enum logic[1:0] flush_state_e {FLUSH_IDLE, FLUSH_DRAIN, FLUSH_INVAL, FLUSH_DONE};
//   - functions deriving NumSets and IdxW from CVA6Cfg.
//   Flat FSM plus index counter; no sub-module.
//   The stats counter is inline, guarded by the macro.
// TESTING
//   1. Ideal: wbuf_empty=1, miss_busy=0, gnt=1; flush_i@0
//      -> 256 requests with idx 0..255, in order, one per cycle from cycle 2; ack@258;
//         stats build: flush_cycles_o=258.
//   2. Drain stall: wbuf_empty=0 for cycles 0..9, flush_i@0
//      -> no tag_req_o before cycle 11; first req idx=0; ack@268.
//   3. Backpressure: gnt low every other cycle
//      -> idx held stable while gnt=0; no set skipped or repeated; ack@NumSets*2+2.
//   4. Request while busy: second flush_i at cycles 5 and 258(DONE)
//      -> exactly one ack; state IDLE at 259.
//   5. Reset mid-walk: rst_ni low at idx=100
//      -> outputs 0 immediately, no ack; new flush_i restarts at idx=0.
//   6. Wrap: after a complete flush, idx register=0
//      -> next flush starts at 0 and issues exactly 256 grants.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared write-through dcache definitions: geometry config, flush FSM states and helpers.
package wt_cache_pkg;

  typedef struct packed {
    int unsigned DcacheByteSize;
    int unsigned DcacheSetAssoc;
    int unsigned DcacheLineWidth;
  } dcache_cfg_t;

  // 32 KiB, 8-way, 128-bit lines -> 256 sets
  localparam dcache_cfg_t DcacheDefaultCfg = '{
    DcacheByteSize:  32'd32768,
    DcacheSetAssoc:  32'd8,
    DcacheLineWidth: 32'd128
  };

  typedef enum logic [1:0] {
    FLUSH_IDLE  = 2'd0,
    FLUSH_DRAIN = 2'd1,
    FLUSH_INVAL = 2'd2,
    FLUSH_DONE  = 2'd3
  } flush_state_e;

  function automatic int unsigned num_sets(input dcache_cfg_t cfg);
    return cfg.DcacheByteSize / (cfg.DcacheSetAssoc * (cfg.DcacheLineWidth / 32'd8));
  endfunction

  function automatic int unsigned idx_w(input dcache_cfg_t cfg);
    return $clog2(num_sets(cfg));
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/wt_dcache_flush_ctrl.sv
// Full write-through dcache invalidation sequencer: drain, walk all sets, ack.
// Optional flush-duration statistics are enabled with DCACHE_FLUSH_STATS_EN.
module wt_dcache_flush_ctrl
  import wt_cache_pkg::*;
#(
  parameter dcache_cfg_t CVA6Cfg = DcacheDefaultCfg,
  parameter int unsigned NumWays = CVA6Cfg.DcacheSetAssoc,
  parameter int unsigned NumSets = num_sets(CVA6Cfg),
  parameter int unsigned IdxW    = idx_w(CVA6Cfg)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               flush_ack_o,
  input  logic               wbuf_empty_i,
  input  logic               miss_busy_i,
  output logic               tag_req_o,
  input  logic               tag_gnt_i,
  output logic [IdxW-1:0]    tag_idx_o,
  output logic [NumWays-1:0] tag_way_o,
  output logic               tag_valid_o,
  output logic [31:0]        flush_cycles_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSets - 1);

  flush_state_e    state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            drain_ok_q;

  // Drain condition is registered so the decision uses a clean sampled value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FLUSH_IDLE;
      idx_q      <= '0;
      drain_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drain_ok_q <= wbuf_empty_i & ~miss_busy_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_o      = (state_q != FLUSH_IDLE);
    flush_ack_o = 1'b0;
    tag_req_o   = 1'b0;
    tag_idx_o   = '0;
    tag_way_o   = '0;
    tag_valid_o = 1'b0;
    case (state_q)
      FLUSH_IDLE: begin
        if (flush_i) begin
          state_d = FLUSH_DRAIN;
        end else begin
          state_d = FLUSH_IDLE;
        end
      end
      FLUSH_DRAIN: begin
        if (drain_ok_q) begin
          state_d = FLUSH_INVAL;
          idx_d   = '0;
        end else begin
          state_d = FLUSH_DRAIN;
        end
      end
      FLUSH_INVAL: begin
        tag_req_o = 1'b1;
        tag_idx_o = idx_q;
        tag_way_o = '1;
        // Request and index hold until the arbiter grants.
        if (tag_gnt_i) begin
          if (idx_q == LastIdx) begin
            state_d = FLUSH_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      FLUSH_DONE: begin
        flush_ack_o = 1'b1;
        state_d     = FLUSH_IDLE;
      end
      default: begin
        state_d = FLUSH_IDLE;
        idx_d   = '0;
      end
    endcase
  end

`ifdef DCACHE_FLUSH_STATS_EN
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] stat_q, stat_d;

  // The captured value includes the DONE cycle itself.
  always_comb begin
    cnt_d  = cnt_q;
    stat_d = stat_q;
    if ((state_q == FLUSH_IDLE) && (state_d == FLUSH_DRAIN)) begin
      cnt_d = '0;
    end else if (busy_o) begin
      cnt_d = sat_inc32(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
    if (state_q == FLUSH_DONE) begin
      stat_d = sat_inc32(cnt_q);
    end else begin
      stat_d = stat_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      stat_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      stat_q <= stat_d;
    end
  end

  assign flush_cycles_o = stat_q;
`else
  assign flush_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_wt_dcache_flush_ctrl.sv
// Directed scoreboard bench for wt_dcache_flush_ctrl (default 256-set, 8-way geometry).
module tb_wt_dcache_flush_ctrl;

  localparam int NSETS = 256;
  localparam int IDXW  = 8;
  localparam int NWAYS = 8;

  logic             clk;
  logic             rst_n;
  logic             flush_i;
  logic             busy_o;
  logic             flush_ack_o;
  logic             wbuf_empty_i;
  logic             miss_busy_i;
  logic             tag_req_o;
  logic             tag_gnt_i;
  logic [IDXW-1:0]  tag_idx_o;
  logic [NWAYS-1:0] tag_way_o;
  logic             tag_valid_o;
  logic [31:0]      flush_cycles_o;

  int n_cmp;
  int n_err;
  int exp_q[$];

  wt_dcache_flush_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush_i),
    .busy_o         (busy_o),
    .flush_ack_o    (flush_ack_o),
    .wbuf_empty_i   (wbuf_empty_i),
    .miss_busy_i    (miss_busy_i),
    .tag_req_o      (tag_req_o),
    .tag_gnt_i      (tag_gnt_i),
    .tag_idx_o      (tag_idx_o),
    .tag_way_o      (tag_way_o),
    .tag_valid_o    (tag_valid_o),
    .flush_cycles_o (flush_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_ack"}, 32'(flush_ack_o), 32'd0);
    chk({tag, "_req"}, 32'(tag_req_o), 32'd0);
    chk({tag, "_idx"}, 32'(tag_idx_o), 32'd0);
    chk({tag, "_way"}, 32'(tag_way_o), 32'd0);
    chk({tag, "_valid"}, 32'(tag_valid_o), 32'd0);
  endtask

  // One complete flush; cycle 0 is the flush_i cycle. All timing expectations
  // come from the drain/walk/done latency model, not from the DUT.
  task automatic run_flush(input string name, input int stall, input bit bp,
                           input int extra_a, input int extra_b);
    int exp_first;
    int exp_ack;
    int grants;
    exp_first = stall + 2;
    exp_ack   = exp_first + (bp ? 2 * NSETS : NSETS);
    grants    = 0;
    exp_q.delete();
    for (int i = 0; i < NSETS; i++) exp_q.push_back(i);
    for (int c = 0; c <= exp_ack + 4; c++) begin
      flush_i      = (c == 0) || (c == extra_a) || (c == extra_b);
      wbuf_empty_i = (c >= stall);
      tag_gnt_i    = bp ? c[0] : 1'b1;
      chk({name, "_busy"}, 32'(busy_o), 32'((c >= 1) && (c <= exp_ack)));
      chk({name, "_ack"}, 32'(flush_ack_o), 32'(c == exp_ack));
      chk({name, "_req"}, 32'(tag_req_o), 32'((c >= exp_first) && (c < exp_ack)));
      if (tag_req_o) begin
        chk({name, "_way"}, 32'(tag_way_o), 32'hFF);
        chk({name, "_valid"}, 32'(tag_valid_o), 32'd0);
        chk({name, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk({name, "_idx"}, 32'(tag_idx_o), 32'(exp_q[0]));
          if (tag_gnt_i) begin
            void'(exp_q.pop_front());
            grants++;
          end
        end
      end else begin
        chk({name, "_idle_idx"}, 32'(tag_idx_o), 32'd0);
        chk({name, "_idle_way"}, 32'(tag_way_o), 32'd0);
      end
`ifdef DCACHE_FLUSH_STATS_EN
      if (c == exp_ack + 1) chk({name, "_flush_cycles"}, flush_cycles_o, 32'(exp_ack));
`endif
      cyc();
    end
    flush_i      = 1'b0;
    wbuf_empty_i = 1'b1;
    tag_gnt_i    = 1'b0;
    chk({name, "_grants"}, 32'(grants), 32'(NSETS));
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    flush_i      = 1'b0;
    wbuf_empty_i = 1'b1;
    miss_busy_i  = 1'b0;
    tag_gnt_i    = 1'b0;
    cyc();
    cyc();
    chk_all_zero("reset");
    chk("reset_flush_cycles", flush_cycles_o, 32'd0);
    rst_n = 1'b1;
    cyc();

    run_flush("ideal", 0, 1'b0, -1, -1);
    run_flush("drain_stall", 10, 1'b0, -1, -1);
    run_flush("backpressure", 0, 1'b1, -1, -1);
    run_flush("busy_req", 0, 1'b0, 5, 258);

    // Abort the walk with async reset while set 100 is being requested.
    wbuf_empty_i = 1'b1;
    tag_gnt_i    = 1'b1;
    for (int c = 0; c < 102; c++) begin
      flush_i = (c == 0);
      cyc();
    end
    flush_i = 1'b0;
    chk("midwalk_req", 32'(tag_req_o), 32'd1);
    chk("midwalk_idx", 32'(tag_idx_o), 32'd100);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_flush_cycles", flush_cycles_o, 32'd0);
    cyc();
    cyc();
    chk_all_zero("held_rst");
    rst_n     = 1'b1;
    tag_gnt_i = 1'b0;
    cyc();
    chk_all_zero("post_rst");

    run_flush("restart", 0, 1'b0, -1, -1);
    run_flush("wrap", 0, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
